// File: rtl/counter_ctrl_pkg.sv
// Shared types for the run/pause/step counter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  // Encoding is visible on the state output: IDLE=0, RUN=1, PAUSE=2, HALT=3.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  // DE-series pushbuttons read low while held.
  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_edge.sv
// Pushbutton conditioner: 2-flop synchronizer plus falling-edge detect -> 1-cycle press.
// Latency: press is high after the 3rd CLOCK_50 edge following the key going low.
// Backpressure: none; a held key yields exactly one press, no debounce.
//
// Ports:
//   CLOCK_50 - clock
//   Reset    - synchronous active-high reset
//   key_n    - raw active-low pushbutton, asynchronous to CLOCK_50
//   press    - registered one-cycle press pulse
module key_edge
  import counter_ctrl_pkg::*;
(
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;
  // smp1/smp2 track when sync2 holds a real sample rather than its reset value.
  logic smp1;
  logic smp2;
  // A key held through reset release must be seen released before it can arm.
  logic armed;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      smp1  <= 1'b0;
      smp2  <= 1'b0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
      smp1  <= 1'b1;
      smp2  <= smp1;
      armed <= armed | (smp2 & (sync2 != KEY_PRESSED));
      press <= armed & (prev != KEY_PRESSED) & (sync2 == KEY_PRESSED);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/step sequencer turning pushbuttons into Enable/Clear strobes for the board counter.
// Latency: strobes and state update one edge after the deciding press pulse or prescaler tick.
// Backpressure: none; strobes are single-cycle and unacknowledged.
//
// Ports:
//   CLOCK_50                - clock
//   Reset                   - synchronous active-high reset
//   start_n, stop_n, step_n - raw active-low pushbuttons
//   wrap_en                 - 1 = wrap to 0 at LIMIT, 0 = halt at LIMIT
//   Q                       - counter value fed back from the counter
//   Enable, Clear           - registered one-cycle strobes to the counter
//   state                   - current FSM state
//   done                    - high while in HALT
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned       TICK_DIV = 5,
  parameter int unsigned       CNT_W    = 10,
  parameter logic [CNT_W-1:0]  LIMIT    = 10'h3FF
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             step_n,
  input  logic             wrap_en,
  input  logic [CNT_W-1:0] Q,
  output logic             Enable,
  output logic             Clear,
  output logic [1:0]       state,
  output logic             done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_press;
  logic stop_press;
  logic step_press;

  key_edge u_start (.CLOCK_50(CLOCK_50), .Reset(Reset), .key_n(start_n), .press(start_press));
  key_edge u_stop  (.CLOCK_50(CLOCK_50), .Reset(Reset), .key_n(stop_n),  .press(stop_press));
  key_edge u_step  (.CLOCK_50(CLOCK_50), .Reset(Reset), .key_n(step_n),  .press(step_press));

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enable_q, enable_d;
  logic          clear_q, clear_d;

  logic start_p;
  logic stop_p;
  logic step_p;
  logic tick;
  logic count_evt;

  // stop > start > step; losers in the same cycle are dropped.
  assign stop_p  = stop_press;
  assign start_p = start_press & ~stop_press;
  assign step_p  = step_press & ~stop_press & ~start_press;

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    enable_d  = 1'b0;
    clear_d   = 1'b0;
    count_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
          clear_d = 1'b1;
          presc_d = '0;
        end
      end
      RUN: begin
        // Stopping freezes the prescaler so a later resume keeps its phase.
        if (stop_p) begin
          state_d = PAUSE;
        end else begin
          presc_d   = tick ? '0 : presc_q + PW'(1);
          count_evt = tick;
        end
      end
      PAUSE: begin
        if (stop_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_p) begin
          state_d = RUN;
        end else if (step_p) begin
          count_evt = 1'b1;
        end
      end
      HALT: begin
        if (stop_p) begin
          state_d = IDLE;
        end else if (start_p) begin
          state_d = RUN;
          clear_d = 1'b1;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Q is only consulted here, so changes between events are ignored.
    if (count_evt) begin
      if (Q != LIMIT) begin
        enable_d = 1'b1;
      end else if (wrap_en) begin
        clear_d = 1'b1;
      end else begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      enable_q <= enable_d;
      clear_q  <= clear_d;
    end
  end

  assign Enable = enable_q;
  assign Clear  = clear_q;
  assign state  = state_q;
  assign done   = (state_q == HALT);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with TICK_DIV=4, LIMIT=5 and an attached counter model.
module tb_counter_ctrl;

  localparam int unsigned CNT_W = 10;

  logic             CLOCK_50 = 1'b0;
  logic             Reset;
  logic             start_n;
  logic             stop_n;
  logic             step_n;
  logic             wrap_en;
  logic [CNT_W-1:0] Q;
  logic             Enable;
  logic             Clear;
  logic [1:0]       state;
  logic             done;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(
    .TICK_DIV(4),
    .CNT_W   (CNT_W),
    .LIMIT   (10'd5)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .start_n (start_n),
    .stop_n  (stop_n),
    .step_n  (step_n),
    .wrap_en (wrap_en),
    .Q       (Q),
    .Enable  (Enable),
    .Clear   (Clear),
    .state   (state),
    .done    (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Counter model driven by the strobes.
  always_ff @(posedge CLOCK_50) begin
    if (Reset)       Q <= '0;
    else if (Clear)  Q <= '0;
    else if (Enable) Q <= Q + 10'd1;
  end

  typedef enum {C_START, C_STOP, C_STEP, C_START_STOP} cmd_t;

  typedef struct {
    int         gap;
    cmd_t       cmd;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       dn;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [1:0] st, input logic en,
                          input logic clr, input logic dn);
    chk({name, " state"},  {30'd0, state}, {30'd0, st});
    chk({name, " Enable"}, {31'd0, Enable}, {31'd0, en});
    chk({name, " Clear"},  {31'd0, Clear},  {31'd0, clr});
    chk({name, " done"},   {31'd0, done},   {31'd0, dn});
  endtask

  // Key low for one edge; the FSM reacts on the 4th edge, where outputs are then visible.
  task automatic press(input cmd_t c);
    start_n = (c == C_START || c == C_START_STOP) ? 1'b0 : 1'b1;
    stop_n  = (c == C_STOP  || c == C_START_STOP) ? 1'b0 : 1'b1;
    step_n  = (c == C_STEP) ? 1'b0 : 1'b1;
    tick();
    start_n = 1'b1;
    stop_n  = 1'b1;
    step_n  = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic apply_vec(input int i);
    for (int g = 0; g < vecs[i].gap; g++) tick();
    press(vecs[i].cmd);
    chk_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].dn);
  endtask

  initial begin
    logic       exp_en;
    logic       exp_clr;
    logic [1:0] exp_st;

    //             gap cmd           st  en clr dn
    vecs[0]  = '{0, C_STEP,       2'd3, 0, 0, 1};  // HALT ignores step
    vecs[1]  = '{0, C_START,      2'd1, 0, 1, 0};  // HALT -> RUN with Clear
    vecs[2]  = '{2, C_STOP,       2'd2, 0, 0, 0};  // RUN -> PAUSE, prescaler held at 1
    vecs[3]  = '{0, C_STEP,       2'd2, 1, 0, 0};  // single count events
    vecs[4]  = '{0, C_STEP,       2'd2, 1, 0, 0};
    vecs[5]  = '{0, C_STEP,       2'd2, 1, 0, 0};
    vecs[6]  = '{0, C_START,      2'd1, 0, 0, 0};  // resume without clear
    vecs[7]  = '{0, C_START_STOP, 2'd2, 0, 0, 0};  // stop wins, tick suppressed
    vecs[8]  = '{0, C_STOP,       2'd0, 0, 1, 0};  // PAUSE -> IDLE with Clear
    vecs[9]  = '{0, C_STEP,       2'd0, 0, 0, 0};  // IDLE ignores step
    vecs[10] = '{0, C_STOP,       2'd0, 0, 0, 0};  // IDLE ignores stop
    vecs[11] = '{0, C_START,      2'd1, 0, 1, 0};  // IDLE -> RUN with Clear

    Reset   = 1'b1;
    start_n = 1'b1;
    stop_n  = 1'b1;
    step_n  = 1'b1;
    wrap_en = 1'b1;

    tick();
    chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    repeat (4) tick();
    chk_outs("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Start from IDLE, then run through a wrap and on to a halt.
    press(C_START);
    chk_outs("start", 2'd1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      if (k == 25) wrap_en = 1'b0;
      tick();
      exp_en  = ((k % 4) == 0) && (k != 24) && (k != 48);
      exp_clr = (k == 24);
      exp_st  = (k >= 48) ? 2'd3 : 2'd1;
      chk_outs($sformatf("run k=%0d", k), exp_st, exp_en, exp_clr, (k >= 48));
      if (k == 21) chk("run q at limit", {22'd0, Q}, 32'd5);
      if (k == 25) chk("run q after wrap", {22'd0, Q}, 32'd0);
      if (k == 47) chk("run q before halt", {22'd0, Q}, 32'd5);
    end

    for (int i = 0; i <= 6; i++) apply_vec(i);
    chk("q after steps", {22'd0, Q}, 32'd4);

    // Held prescaler phase: tick three edges after resume, not four.
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_outs($sformatf("resume k=%0d", k), 2'd1, (k == 3), 1'b0, 1'b0);
    end

    for (int i = 7; i <= 11; i++) apply_vec(i);

    // Reset mid-run at prescaler 2 with start held low through release.
    tick();
    tick();
    Reset   = 1'b1;
    start_n = 1'b0;
    tick();
    chk_outs("mid reset", 2'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("held key k=%0d state", k), {30'd0, state}, 32'd0);
    end
    start_n = 1'b1;
    repeat (4) tick();
    chk_outs("key released", 2'd0, 1'b0, 1'b0, 1'b0);
    press(C_START);
    chk_outs("start after reset", 2'd1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Enable and Clear must never be high together.
  always @(negedge CLOCK_50) begin
    if (Enable && Clear) begin
      errors++;
      $display("FAIL strobe overlap: Enable=%0d Clear=%0d required not both 1", Enable, Clear);
    end
  end

endmodule
